// File: rtl/inst_sequencer.sv
// Instruction sequencer: holds the instruction register and T-state counter,
// arbitrates reset/NMI/IRQ entry at instruction boundaries, and halts on cycle overflow.
module inst_sequencer #(
  parameter int CYCW = 3,
  parameter int NIRQ = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            rdy,
  input  logic [7:0]      opcode,
  input  logic            icyc,
  input  logic            rcyc,
  input  logic            sinst,
  input  logic            irqdis,
  input  logic            nmi,
  input  logic [NIRQ-1:0] irq,
  output logic [7:0]      inst,
  output logic [CYCW-1:0] cycle,
  output logic            clr_o,
  output logic            nmi_o,
  output logic            irq_o,
  output logic [IDW-1:0]  irqsel,
  output logic            busy,
  output logic            cycovf
);

  typedef enum logic [1:0] {RSTSEQ, EXEC, IDLE, HALT} state_t;

  localparam logic [CYCW-1:0] CYC_MAX = '1;

  state_t          state;
  logic            nmi_prev;
  logic            nmi_pend;
  logic            nmi_clr;
  logic [IDW-1:0]  irq_low;

  assign nmi_o = nmi_pend;
  assign irq_o = (|irq) & ~irqdis & ~nmi_pend;

  // Descending scan leaves the lowest asserted index
  always_comb begin
    irq_low = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (irq[i]) irq_low = IDW'(i);
    end
  end

  assign nmi_clr = sinst && (state == EXEC || state == IDLE) && (inst == 8'h00) && !clr_o;

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= RSTSEQ;
      inst     <= 8'h00;
      cycle    <= '0;
      clr_o    <= 1'b1;
      nmi_pend <= 1'b0;
      nmi_prev <= 1'b0;
      irqsel   <= '0;
      cycovf   <= 1'b0;
      busy     <= 1'b1;
    end else begin
      nmi_prev <= nmi;
      if (nmi && !nmi_prev) nmi_pend <= 1'b1;
      else if (nmi_clr)     nmi_pend <= 1'b0;

      if (rdy) begin
        case (state)
          RSTSEQ: begin
            if (sinst) begin
              clr_o <= 1'b0;
              state <= EXEC;
              busy  <= 1'b1;
            end
            // An overflow below overrides the sinst transition
            if (rcyc) begin
              cycle <= '0;
            end else if (icyc) begin
              if (cycle == CYC_MAX) begin
                cycovf <= 1'b1;
                state  <= HALT;
                busy   <= 1'b1;
              end else begin
                cycle <= cycle + CYCW'(1);
              end
            end
          end
          EXEC, IDLE: begin
            if (rcyc) begin
              cycle <= '0;
              if (clr_o || nmi_pend || irq_o) begin
                inst  <= 8'h00;
                state <= EXEC;
                busy  <= 1'b1;
                if (!clr_o && !nmi_pend) irqsel <= irq_low;
              end else begin
                inst <= opcode;
                if (state == EXEC && opcode == 8'hEA) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end else begin
                  state <= EXEC;
                  busy  <= 1'b1;
                end
              end
            end else if (icyc) begin
              if (cycle == CYC_MAX) begin
                cycovf <= 1'b1;
                state  <= HALT;
                busy   <= 1'b1;
              end else begin
                cycle <= cycle + CYCW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: a behavioural model checked every cycle
// plus hand-computed literal checkpoints along each scenario.
module tb_inst_sequencer;

  localparam int CYCW = 3;
  localparam int NIRQ = 4;
  localparam int IDW  = 2;
  localparam int CMAX = (1 << CYCW) - 1;

  logic            clk = 1'b0;
  logic            clr = 1'b0, rdy = 1'b1, icyc = 1'b0, rcyc = 1'b0, sinst = 1'b0;
  logic            irqdis = 1'b0, nmi = 1'b0;
  logic [7:0]      opcode = 8'h00;
  logic [NIRQ-1:0] irq = '0;
  logic [7:0]      inst;
  logic [CYCW-1:0] cycle;
  logic            clr_o, nmi_o, irq_o, busy, cycovf;
  logic [IDW-1:0]  irqsel;

  int n_checks = 0;
  int n_fail   = 0;

  inst_sequencer #(.CYCW(CYCW), .NIRQ(NIRQ), .IDW(IDW)) dut (
    .clk(clk), .clr(clr), .rdy(rdy), .opcode(opcode), .icyc(icyc), .rcyc(rcyc),
    .sinst(sinst), .irqdis(irqdis), .nmi(nmi), .irq(irq), .inst(inst), .cycle(cycle),
    .clr_o(clr_o), .nmi_o(nmi_o), .irq_o(irq_o), .irqsel(irqsel), .busy(busy), .cycovf(cycovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the sequencer's observable state
  int  m_inst, m_cycle, m_sel;
  bit  m_clr, m_nmi, m_prev, m_ovf, m_halt, m_idle, started;

  function automatic int lowest(input logic [NIRQ-1:0] v);
    for (int i = 0; i < NIRQ; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (clr) begin
      m_inst = 0; m_cycle = 0; m_sel = 0;
      m_clr = 1; m_nmi = 0; m_prev = 0; m_ovf = 0; m_halt = 0; m_idle = 0;
      started = 1;
    end else if (started) begin
      bit new_nmi;
      new_nmi = (nmi && !m_prev) ? 1'b1 :
                ((sinst && !m_halt && m_inst == 0 && !m_clr) ? 1'b0 : m_nmi);
      m_prev = nmi;
      if (rdy && !m_halt) begin
        if (rcyc) begin
          m_cycle = 0;
          if (!m_clr) begin
            if (m_nmi) begin
              m_inst = 0; m_idle = 0;
            end else if ((|irq) && !irqdis) begin
              m_inst = 0; m_sel = lowest(irq); m_idle = 0;
            end else begin
              m_idle = !m_idle && (opcode == 8'hEA);
              m_inst = opcode;
            end
          end
        end else if (icyc) begin
          if (m_cycle == CMAX) begin
            m_ovf = 1; m_halt = 1; m_idle = 0;
          end else begin
            m_cycle++;
          end
        end
        if (m_clr && sinst) m_clr = 0;
      end
      m_nmi = new_nmi;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("inst",   int'(inst),   m_inst);
      check("cycle",  int'(cycle),  m_cycle);
      check("clr_o",  int'(clr_o),  int'(m_clr));
      check("nmi_o",  int'(nmi_o),  int'(m_nmi));
      check("irq_o",  int'(irq_o),  int'((|irq) && !irqdis && !m_nmi));
      check("irqsel", int'(irqsel), m_sel);
      check("busy",   int'(busy),   int'(!m_idle));
      check("cycovf", int'(cycovf), int'(m_ovf));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    // Reset then fetch
    clr = 1; tick(); clr = 0;
    check("rst_inst", int'(inst), 8'h00);
    check("rst_cycle", int'(cycle), 0);
    check("rst_clr_o", int'(clr_o), 1);
    check("rst_busy", int'(busy), 1);
    check("rst_cycovf", int'(cycovf), 0);
    sinst = 1; tick(); sinst = 0;
    check("fetch_clr_o", int'(clr_o), 0);
    icyc = 1; tick(7); icyc = 0;
    check("fetch_cycle7", int'(cycle), 7);
    opcode = 8'hA9; rcyc = 1; tick(); rcyc = 0;
    check("fetch_inst", int'(inst), 8'hA9);
    check("fetch_cycle0", int'(cycle), 0);

    // Overflow into HALT
    opcode = 8'h69; rcyc = 1; tick(); rcyc = 0;
    icyc = 1; tick(8); icyc = 0;
    check("ovf_cycle", int'(cycle), 7);
    check("ovf_flag", int'(cycovf), 1);
    rcyc = 1; tick(); rcyc = 0;
    check("halt_inst", int'(inst), 8'h69);
    check("halt_cycle", int'(cycle), 7);
    clr = 1; tick(); clr = 0;
    check("recover_cycovf", int'(cycovf), 0);
    check("recover_clr_o", int'(clr_o), 1);
    sinst = 1; tick(); sinst = 0;

    // NMI beats IRQ, then IRQ serviced
    irq = 4'b0110; nmi = 1; tick();
    check("prio_nmi_o", int'(nmi_o), 1);
    check("prio_irq_o", int'(irq_o), 0);
    opcode = 8'hA9; rcyc = 1; tick(); rcyc = 0;
    check("prio_inst", int'(inst), 8'h00);
    sinst = 1; tick(); sinst = 0;
    check("prio_nmi_clr", int'(nmi_o), 0);
    check("prio_irq_up", int'(irq_o), 1);
    rcyc = 1; tick(); rcyc = 0;
    check("prio_irqsel", int'(irqsel), 1);
    irq = '0; nmi = 0; tick();

    // Masked IRQ
    irq = 4'b1000; irqdis = 1; opcode = 8'hE8; tick();
    check("mask_irq_o", int'(irq_o), 0);
    rcyc = 1; tick(); rcyc = 0;
    check("mask_inst", int'(inst), 8'hE8);
    irqdis = 0; #1;
    check("unmask_irq_o", int'(irq_o), 1);
    irq = '0; tick();

    // Stall with rdy low
    icyc = 1; tick(2);
    rdy = 0; nmi = 1; tick(3);
    check("stall_cycle", int'(cycle), 2);
    check("stall_inst", int'(inst), 8'hE8);
    check("stall_nmi_o", int'(nmi_o), 1);
    rdy = 1; tick(); icyc = 0;
    check("stall_resume", int'(cycle), 3);
    nmi = 0; rcyc = 1; tick(); rcyc = 0;
    sinst = 1; tick(); sinst = 0;
    check("stall_nmi_clr", int'(nmi_o), 0);

    // icyc and rcyc together, then mid-instruction clr
    opcode = 8'hA9; rcyc = 1; tick(); rcyc = 0;
    icyc = 1; tick(4);
    check("sim_cycle4", int'(cycle), 4);
    rcyc = 1; opcode = 8'h5A; tick(); rcyc = 0;
    check("sim_cycle0", int'(cycle), 0);
    check("sim_inst", int'(inst), 8'h5A);
    tick(5);
    check("sim_cycle5", int'(cycle), 5);
    clr = 1; tick(); clr = 0; icyc = 0;
    check("mid_clr_inst", int'(inst), 8'h00);
    check("mid_clr_cycle", int'(cycle), 0);
    check("mid_clr_clr_o", int'(clr_o), 1);

    // IDLE entry on 0xEA and exit on next rcyc
    sinst = 1; tick(); sinst = 0;
    opcode = 8'hEA; rcyc = 1; tick(); rcyc = 0;
    check("idle_busy", int'(busy), 0);
    opcode = 8'h18; rcyc = 1; tick(); rcyc = 0;
    check("idle_exit_busy", int'(busy), 1);
    check("idle_exit_inst", int'(inst), 8'h18);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_sequencer.md
INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- CYCW, 3, cycle counter width; instruction length limit is 2^CYCW cycles.
- NIRQ, 4, number of maskable interrupt request lines.
- IDW, 2, width of the IRQ index; SHALL equal clog2(NIRQ), minimum 1.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on its rising edge.
- clr  in  1  reset; synchronous, active-high.
- rdy  in  1  advance enable; low freezes sequencing.
- opcode  in  8  opcode byte from the input data latch.
- icyc  in  1  decoder request: advance cycle.
- rcyc  in  1  decoder request: end instruction and load next.
- sinst  in  1  decoder acknowledge: interrupt sequence entered.
- irqdis  in  1  status-register I flag.
- nmi  in  1  non-maskable request; edge-sensitive.
- irq  in  NIRQ  maskable requests; level-sensitive.
- inst  out  8  instruction register, driven to the decoder.
- cycle  out  CYCW  current T-state, driven to the decoder.
- clr_o  out  1  reset sequence pending, to the decoder clr input.
- nmi_o  out  1  NMI pending, to the decoder nmi input.
- irq_o  out  1  unmasked IRQ pending, to the decoder irq input.
- irqsel  out  IDW  index of the IRQ being serviced.
- busy  out  1  high while not in IDLE.
- cycovf  out  1  cycle-overflow error, sticky.

Function
REQ-003 The state machine SHALL have four states: RSTSEQ, EXEC, IDLE and HALT.
REQ-004 In RSTSEQ, inst SHALL equal 0x00 and clr_o SHALL be 1; on sinst with rdy high, the block SHALL clear clr_o and go to EXEC.
REQ-005 In EXEC with rdy high and rcyc high:
- cycle SHALL go to 0.
- The next inst SHALL be chosen by priority: clr_o, then nmi pending, then unmasked IRQ, then opcode.
- Any chosen interrupt SHALL load inst=0x00.
REQ-006 rcyc SHALL take priority over icyc when both are high in the same cycle.
REQ-007 In EXEC with rdy high, icyc high and rcyc low, cycle SHALL increment by 1.
REQ-008 If icyc arrives while cycle equals 2^CYCW-1:
- cycle SHALL hold its value, with no wrap.
- cycovf SHALL be set.
- The state SHALL go to HALT.
REQ-009 HALT SHALL ignore icyc, rcyc and sinst; only clr exits HALT.
REQ-010 When rdy is low, inst, cycle, state and irqsel SHALL hold; pending-flag capture SHALL continue.
REQ-011 NMI detection:
- A rising edge on nmi (registered previous value 0, current 1) SHALL set the NMI pending flag.
- nmi_o SHALL equal that flag.
REQ-012 The NMI pending flag SHALL clear on sinst while inst=0x00 and clr_o=0.
- If a new nmi edge coincides with that clear, the flag SHALL remain set.
REQ-013 irq_o SHALL be combinationally (|irq) & ~irqdis & ~nmi_o.
REQ-014 irqsel SHALL latch the lowest asserted unmasked irq index at the rcyc boundary that selects an IRQ; otherwise it SHALL hold.
REQ-015 The IRQ condition SHALL NOT be latched; deasserting irq before the boundary SHALL cancel the request.
REQ-016 Transitions between EXEC and IDLE:
- EXEC SHALL enter IDLE when a nop-class rcyc loads opcode 0xEA and no request is pending.
- IDLE SHALL behave as EXEC but with busy=0.
- IDLE SHALL return to EXEC on the next rcyc.
REQ-017 cycle arithmetic SHALL be unsigned modulo-free: saturating with error, per REQ-008.

Reset
REQ-018 While clr is high at a rising clk edge, the block SHALL load these values:
- inst=0x00, cycle=0.
- clr_o=1, NMI pending=0, registered nmi=0.
- irqsel=0, cycovf=0, busy=1.
- state=RSTSEQ.
REQ-019 clr SHALL override every other input in the same cycle, including mid-instruction and in HALT.
REQ-020 After clr deasserts, the block SHALL remain in RSTSEQ until sinst; icyc SHALL still advance cycle in RSTSEQ.

Verification
REQ-021 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Reset then fetch: clr 1 cycle, sinst at cycle 0, 7 icyc, rcyc with opcode=0xA9 -> clr_o 1->0; cycle 0..7; then inst=0xA9, cycle=0.
- Overflow: CYCW=3, opcode=0x69, 8 icyc without rcyc -> cycle stays 7, cycovf=1, state HALT; a later rcyc has no effect; clr recovers.
- Priority: nmi rising edge and irq=4'b0110 with irqdis=0, then rcyc -> inst=0x00, nmi_o=1, irq_o=0; sinst clears nmi_o; next rcyc -> irq_o=1, irqsel=1.
- Mask: irq=4'b1000 with irqdis=1, then rcyc with opcode=0xE8 -> inst=0xE8, irq_o=0; clearing irqdis -> irq_o=1.
- Stall: rdy=0 for 3 cycles with icyc=1 and an nmi edge -> cycle and inst unchanged, nmi_o=1; rdy=1 -> cycle advances by 1.
- Simultaneous: icyc and rcyc in the same cycle at cycle=4 -> cycle=0 and inst loaded; a mid-instruction clr at cycle=5 -> all reset values on the next edge.
